kbd_tx_buffer: RTL and testbench
================================

Name: kbd_tx_buffer

Overview:
- Elastic buffer between the PS/2 keyboard decoder (one-cycle ASCII valid pulses) and the UART transmitter (busy-handshaked parallel input).
- Queues keystrokes so that bursts (typematic repeat, multi-byte sequences) are not lost while the UART is still shifting the previous byte.
- Optionally expands CR into CR LF.
- Drains bytes one at a time, using the UART busy signal as the acknowledge.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, minimum 2.
- ACK_TIMEOUT, 64: clk cycles to wait for txBusy to rise after a valid pulse before the byte is treated as sent.
- CRLF_EXPAND, 0: when 1, every popped 0x0D is followed by an inserted 0x0A.

Ports:
- clk  in  1  system clock (24 MHz)
- resetn  in  1  asynchronous active-low reset
- kbdData  in  8  ASCII byte from the keyboard decoder
- kbdDataValid  in  1  one-cycle strobe qualifying kbdData
- txBusy  in  1  UART transmitter busy
- txData  out  8  byte presented to the UART
- txDataValid  out  1  one-cycle strobe to the UART
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full
- clearOverflow  in  1  synchronous clear of overflow

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous assert, active-low, and is the only reset.
- Reset values:
  - txData = 0x00, txDataValid = 0, count = 0, overflow = 0.
  - Read and write pointers = 0.
  - FSM = IDLE; the CRLF pending flag = 0.
  - FIFO RAM contents are don't-care.
- Write side:
  - kbdDataValid=1 and count<DEPTH (registered value) → store kbdData at wrPtr, wrPtr+1 modulo DEPTH.
  - kbdDataValid=1 and count==DEPTH → byte dropped, overflow<=1. A pop in the same cycle does not rescue the write.
  - clearOverflow and an overflow event in the same cycle → overflow stays 1.
- Count: +1 on accepted write, −1 on pop, unchanged when both occur in the same cycle. It never wraps.
- Read FSM (states IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE):
  - IDLE:
    - If crlfPending=1 and txBusy=0 → txData<=0x0A, crlfPending<=0, go to ISSUE.
    - Else if count>0 and txBusy=0 → LOAD.
  - LOAD: txData<=mem[rdPtr], rdPtr+1, count decremented (pop). If CRLF_EXPAND=1 and the byte is 0x0D, set crlfPending<=1. → ISSUE.
  - ISSUE: txDataValid=1 for exactly this cycle. Reset the timeout counter. → WAIT_ACK.
  - WAIT_ACK:
    - txBusy=1 → WAIT_DONE.
    - Otherwise the timeout counter increments. At ACK_TIMEOUT−1 → IDLE (byte abandoned, not retried).
  - WAIT_DONE: txBusy=0 → IDLE.
- Latency: a write into an empty FIFO with txBusy=0 produces txDataValid 3 cycles after the kbdDataValid cycle (write, IDLE sees count, LOAD → ISSUE).
- Throughput: at most one byte per UART frame.
- txData holds its value from LOAD until the next LOAD or the CRLF insert.
- The inserted LF occupies no FIFO entry and does not change count.
- Reset mid-operation (any state): all state returns to reset values immediately. Queued bytes and any pending LF are discarded.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from count, not from pointer compare.

Decomposition:
- Shared package (vgaminikbd.vh): FSM state encodings (3 bits), ASCII_CR=8'h0D, ASCII_LF=8'h0A.
- One sub-module, sync_fifo:
  - Parameterised width/depth.
  - Async active-low reset.
  - Ports: push, pop, din, dout, count, full, empty. dout is registered on pop.
  - Reusable later for the RX path.
- The FSM, timeout counter and CRLF logic stay in kbd_tx_buffer.
- Integration: insert between ukbd and uuart0.dataInTx/dataInTxValid, and connect dataInTxBusy to txBusy.

Test Plan:
- Single byte, idle UART: push 0x41; the bench asserts txBusy for 20 cycles starting 1 cycle after txDataValid → txData=0x41, txDataValid high exactly 1 cycle, 3 cycles after the push; count returns to 0.
- Burst: push 0x61..0x70 (16 bytes) on consecutive cycles while txBusy=1 → count=16, overflow=0. Push 0x71 → dropped, overflow=1. Release busy → exactly 16 bytes emitted in order 0x61..0x70. clearOverflow → overflow=0.
- Simultaneous push/pop: with count=3, push in the same cycle as the LOAD pop → count stays 3; after drain, bytes appear in FIFO order.
- CRLF_EXPAND=1: push 0x0D, 0x42 → the UART sees 0x0D, 0x0A, 0x42. count never exceeds 2.
- Ack timeout: txBusy held 0 after the ISSUE of 0x55 → FSM returns to IDLE after ACK_TIMEOUT cycles and the next queued byte 0x56 is issued; 0x55 is not repeated.
- Reset mid-operation: 5 bytes queued, FSM in WAIT_DONE; pulse resetn low asynchronously → count=0, txDataValid=0, txData=0x00 immediately; no further emission after release.

Source files
------------

// File: rtl/kbd_tx_buffer_pkg.sv
// Shared definitions for the keyboard-to-UART transmit buffer.
//   txState_e  : read-side FSM state encoding (3 bits)
//   ASCII_CR   : carriage return, the byte that triggers LF insertion
//   ASCII_LF   : line feed, the inserted byte
//   timerWidth : bits needed to hold a down-counter loaded with n-1
package kbd_tx_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } txState_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int timerWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kbd_tx_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : write request and data; ignored while full
//   pop, dout   : read request; dout is registered and updates on an accepted pop
//   count       : current occupancy, 0..DEPTH
//   full, empty : derived from count, not from pointer comparison
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Storage needs no reset; its contents are only read behind count.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
        dout  <= mem[rdPtr];
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_tx_buffer.sv
// Elastic buffer between the PS/2 keyboard decoder and the UART transmitter.
//   clk, resetn            : clock, asynchronous active-low reset
//   kbdData, kbdDataValid  : keystroke byte and its one-cycle strobe
//   txBusy                 : UART busy, used as the acknowledge for each byte
//   txData, txDataValid    : byte and one-cycle strobe towards the UART
//   count                  : FIFO occupancy (the inserted LF is not counted)
//   overflow               : sticky, set when a keystroke hit a full FIFO
//   clearOverflow          : synchronous clear of overflow
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | UART free? send pending LF first, otherwise fetch next byte
// LOAD      | pop the FIFO head into the output register
// ISSUE     | txDataValid high for this one cycle, arm the ack timer
// WAIT_ACK  | wait for txBusy to rise; give up when the timer expires
// WAIT_DONE | wait for the UART to finish the frame
module kbd_tx_buffer
  import kbd_tx_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int CRLF_EXPAND = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               kbdData,
  input  logic                     kbdDataValid,
  input  logic                     txBusy,
  output logic [7:0]               txData,
  output logic                     txDataValid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clearOverflow
);

  localparam int TW = timerWidth(ACK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT - 1);

  txState_e      state;
  txState_e      nextState;
  logic [TW-1:0] ackTimer;
  logic          crlfPending;
  logic          lfSel;
  logic          fifoPop;
  logic          takeLf;
  logic [7:0]    fifoDout;
  logic          fifoFull;
  logic          fifoEmpty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (kbdDataValid),
    .pop    (fifoPop),
    .din    (kbdData),
    .dout   (fifoDout),
    .count  (count),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // The popped byte lives in the FIFO's registered dout; an inserted LF is
  // selected over it until the next pop, so txData holds between loads.
  assign txData      = lfSel ? ASCII_LF : fifoDout;
  assign txDataValid = (state == ISSUE);

  always_comb begin
    nextState = state;
    fifoPop   = 1'b0;
    takeLf    = 1'b0;
    case (state)
      IDLE: begin
        if (crlfPending && !txBusy) begin
          takeLf    = 1'b1;
          nextState = ISSUE;
        end else if (!fifoEmpty && !txBusy) begin
          nextState = LOAD;
        end
      end
      LOAD: begin
        fifoPop   = 1'b1;
        nextState = ISSUE;
      end
      ISSUE: begin
        nextState = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (txBusy) begin
          nextState = WAIT_DONE;
        end else if (ackTimer == '0) begin
          nextState = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!txBusy) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ackTimer    <= '0;
      crlfPending <= 1'b0;
      lfSel       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= nextState;

      // Down-counter: WAIT_ACK lasts ACK_TIMEOUT cycles without an ack.
      if (state == ISSUE) begin
        ackTimer <= TIMER_LOAD;
      end else if (state == WAIT_ACK && ackTimer != '0) begin
        ackTimer <= ackTimer - 1'b1;
      end

      if (takeLf) begin
        crlfPending <= 1'b0;
        lfSel       <= 1'b1;
      end else begin
        if (fifoPop) begin
          lfSel <= 1'b0;
        end
        // The popped byte is visible on dout in ISSUE; a CR arms the LF.
        if (CRLF_EXPAND != 0 && state == ISSUE && !lfSel && fifoDout == ASCII_CR) begin
          crlfPending <= 1'b1;
        end
      end

      // A drop wins over a simultaneous clear.
      if (kbdDataValid && fifoFull) begin
        overflow <= 1'b1;
      end else if (clearOverflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_tx_buffer.sv
module tb_kbd_tx_buffer;

  localparam int DEPTH = 16;
  localparam int TMO   = 12;

  // Reference-model phases of the sender (index 0: plain, index 1: CR->CRLF)
  localparam int QUIET      = 0;
  localparam int FETCH      = 1;
  localparam int STROBE     = 2;
  localparam int AWAIT_BUSY = 3;
  localparam int AWAIT_FREE = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] kbdData = 8'h00;
  logic       kbdDataValid = 1'b0;
  logic       clearOverflow = 1'b0;

  logic       txBusy [2];
  logic [7:0] txData [2];
  logic       txDataValid [2];
  logic [4:0] count [2];
  logic       overflow [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int maxCnt1 = 0;

  // reference model state
  logic [7:0] mq [2][$];
  int         mMode [2];
  int         mWait [2];
  logic [7:0] mData [2];
  bit         mLfPend [2];
  bit         mOvf [2];

  // UART stand-in
  int         uRemain [2];
  bit         uRespond = 1'b1;
  bit         uHold = 1'b0;
  int         uFrame = 20;
  logic [7:0] emitted [2][$];
  int         emitCyc [2][$];

  kbd_tx_buffer #(.DEPTH(DEPTH), .ACK_TIMEOUT(TMO), .CRLF_EXPAND(0)) dut0 (
    .clk(clk), .resetn(resetn), .kbdData(kbdData), .kbdDataValid(kbdDataValid),
    .txBusy(txBusy[0]), .txData(txData[0]), .txDataValid(txDataValid[0]),
    .count(count[0]), .overflow(overflow[0]), .clearOverflow(clearOverflow));

  kbd_tx_buffer #(.DEPTH(DEPTH), .ACK_TIMEOUT(TMO), .CRLF_EXPAND(1)) dut1 (
    .clk(clk), .resetn(resetn), .kbdData(kbdData), .kbdDataValid(kbdDataValid),
    .txBusy(txBusy[1]), .txData(txData[1]), .txDataValid(txDataValid[1]),
    .count(count[1]), .overflow(overflow[1]), .clearOverflow(clearOverflow));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelStep(input int i);
    bit         accept;
    logic [7:0] b;
    accept = kbdDataValid && (mq[i].size() < DEPTH);
    case (mMode[i])
      QUIET: begin
        if (!txBusy[i]) begin
          if (mLfPend[i]) begin
            mData[i]   = 8'h0A;
            mLfPend[i] = 1'b0;
            mMode[i]   = STROBE;
          end else if (mq[i].size() > 0) begin
            mMode[i] = FETCH;
          end
        end
      end
      FETCH: begin
        b        = mq[i].pop_front();
        mData[i] = b;
        if (i == 1 && b == 8'h0D) mLfPend[i] = 1'b1;
        mMode[i] = STROBE;
      end
      STROBE: begin
        mWait[i] = 0;
        mMode[i] = AWAIT_BUSY;
      end
      AWAIT_BUSY: begin
        if (txBusy[i]) mMode[i] = AWAIT_FREE;
        else if (mWait[i] == TMO - 1) mMode[i] = QUIET;
        else mWait[i]++;
      end
      AWAIT_FREE: begin
        if (!txBusy[i]) mMode[i] = QUIET;
      end
      default: mMode[i] = QUIET;
    endcase
    if (accept) mq[i].push_back(kbdData);
    if (kbdDataValid && !accept) mOvf[i] = 1'b1;
    else if (clearOverflow) mOvf[i] = 1'b0;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        mMode[i]   = QUIET;
        mWait[i]   = 0;
        mData[i]   = 8'h00;
        mLfPend[i] = 1'b0;
        mOvf[i]    = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) modelStep(i);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int act;
      int exp;
      act = {txDataValid[i], txData[i], count[i], overflow[i]};
      exp = {(mMode[i] == STROBE), mData[i], 5'(mq[i].size()), mOvf[i]};
      check($sformatf("dut%0d cycle %0d {valid,data,count,ovf}", i, cyc), act, exp);
    end
    if (int'(count[1]) > maxCnt1) maxCnt1 = int'(count[1]);
  end

  // UART stand-in: logs each strobe, then raises busy for uFrame cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        uRemain[i] = 0;
        txBusy[i]  = 1'b0;
      end else begin
        if (txDataValid[i]) begin
          emitted[i].push_back(txData[i]);
          emitCyc[i].push_back(cyc);
          if (uRespond) uRemain[i] = uFrame;
        end
        if (uHold) begin
          txBusy[i] = 1'b1;
        end else if (uRemain[i] > 0) begin
          txBusy[i] = 1'b1;
          uRemain[i]--;
        end else begin
          txBusy[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    kbdData      = b;
    kbdDataValid = 1'b1;
    tick();
    kbdDataValid = 1'b0;
  endtask

  task automatic clearEmit();
    for (int i = 0; i < 2; i++) begin
      emitted[i].delete();
      emitCyc[i].delete();
    end
  endtask

  task automatic checkSeq(input string name, input int i, input logic [7:0] exp[$]);
    check($sformatf("%s dut%0d length", name, i), emitted[i].size(), exp.size());
    for (int k = 0; k < exp.size() && k < emitted[i].size(); k++)
      check($sformatf("%s dut%0d byte %0d", name, i, k), emitted[i][k], exp[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] expq [$];
    int  t0;
    bit  seen;

    // reset values
    repeat (3) tick();
    check("reset count", count[0], 0);
    check("reset txData", txData[0], 0);
    check("reset txDataValid", txDataValid[0], 0);
    check("reset overflow", overflow[0], 0);
    resetn = 1'b1;
    repeat (2) tick();

    // single byte into an idle UART
    clearEmit();
    uRespond = 1'b1;
    uFrame   = 20;
    t0 = cyc;
    push(8'h41);
    repeat (30) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("single dut%0d strobes", i), emitted[i].size(), 1);
      if (emitted[i].size() >= 1) begin
        check($sformatf("single dut%0d data", i), emitted[i][0], 8'h41);
        check($sformatf("single dut%0d latency", i), emitCyc[i][0] - t0, 3);
      end
      check($sformatf("single dut%0d count", i), count[i], 0);
    end

    // burst into a busy UART, then overflow
    clearEmit();
    uHold = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 16; k++) push(8'(8'h61 + k));
    check("burst count", count[0], 16);
    check("burst overflow before", overflow[0], 0);
    push(8'h71);
    check("burst overflow dut0", overflow[0], 1);
    check("burst overflow dut1", overflow[1], 1);
    check("burst count after drop", count[0], 16);
    uHold  = 1'b0;
    uFrame = 4;
    repeat (200) tick();
    expq.delete();
    for (int k = 0; k < 16; k++) expq.push_back(8'(8'h61 + k));
    checkSeq("burst", 0, expq);
    checkSeq("burst", 1, expq);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    tick();
    check("overflow cleared", overflow[0], 0);

    // push in the same cycle as a pop
    clearEmit();
    uHold = 1'b1;
    repeat (2) tick();
    push(8'h31);
    push(8'h32);
    push(8'h33);
    uHold = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (mMode[0] == FETCH) seen = 1'b1;
      else tick();
    end
    check("simultaneous pop reached", seen, 1);
    push(8'h34);
    check("simultaneous count dut0", count[0], 3);
    check("simultaneous count dut1", count[1], 3);
    repeat (100) tick();
    expq = '{8'h31, 8'h32, 8'h33, 8'h34};
    checkSeq("fifo order", 0, expq);

    // CR expansion
    clearEmit();
    maxCnt1 = 0;
    push(8'h0D);
    push(8'h42);
    repeat (80) tick();
    expq = '{8'h0D, 8'h42};
    checkSeq("no crlf", 0, expq);
    expq = '{8'h0D, 8'h0A, 8'h42};
    checkSeq("crlf", 1, expq);
    check("crlf count bounded", (maxCnt1 <= 2), 1);

    // ack timeout: the UART never goes busy
    clearEmit();
    uRespond = 1'b0;
    push(8'h55);
    push(8'h56);
    repeat (2 * TMO + 20) tick();
    uRespond = 1'b1;
    expq = '{8'h55, 8'h56};
    checkSeq("timeout", 0, expq);
    checkSeq("timeout", 1, expq);
    if (emitCyc[0].size() >= 2)
      check("timeout spacing", emitCyc[0][1] - emitCyc[0][0], TMO + 3);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      kbdDataValid  = ($urandom_range(0, 3) == 0);
      kbdData       = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
      clearOverflow = ($urandom_range(0, 15) == 0);
      uFrame        = $urandom_range(1, 6);
      uRespond      = ($urandom_range(0, 7) != 0);
      tick();
    end
    kbdDataValid  = 1'b0;
    clearOverflow = 1'b0;
    uRespond      = 1'b1;
    repeat (300) tick();

    // reset in the middle of a frame
    clearEmit();
    uFrame = 200;
    for (int k = 0; k < 6; k++) push(8'(8'h81 + k));
    repeat (10) tick();
    check("pre-reset count dut0", count[0], 5);
    check("pre-reset count dut1", count[1], 5);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async reset dut%0d count", i), count[i], 0);
      check($sformatf("async reset dut%0d txDataValid", i), txDataValid[i], 0);
      check($sformatf("async reset dut%0d txData", i), txData[i], 0);
    end
    @(negedge clk);
    #1;
    resetn = 1'b1;
    clearEmit();
    uFrame = 4;
    repeat (40) tick();
    check("post-reset emissions dut0", emitted[0].size(), 0);
    check("post-reset emissions dut1", emitted[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
